// File: rtl/hls_kernel_run_monitor.sv
// Run controller and latency monitor for a Bambu HLS kernel: pulses start_port,
// times done_port and keeps per-campaign stats. Optional: HLS_RUN_MON_MISMATCH_EN.
module hls_kernel_run_monitor #(
    parameter int CYCLE_W        = 32,
    parameter int RUN_CNT_W      = 8,
    parameter int TOTAL_W        = 40,
    parameter int TIMEOUT_CYCLES = 200000000,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 go,
    input  logic [RUN_CNT_W-1:0] num_runs,
    output logic                 start_port,
    input  logic                 done_port,
    output logic                 busy,
    output logic                 campaign_done,
    output logic                 timeout,
    output logic [RUN_CNT_W-1:0] runs_done,
    output logic [CYCLE_W-1:0]   last_cycles,
    output logic [CYCLE_W-1:0]   min_cycles,
    output logic [CYCLE_W-1:0]   max_cycles,
    output logic [TOTAL_W-1:0]   total_cycles,
    output logic                 latency_mismatch,
    output logic [RUN_CNT_W-1:0] mismatch_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CYCLE_W-1:0] CYC_MAX  = {CYCLE_W{1'b1}};
    localparam logic [CYCLE_W-1:0] TO_LAST  = CYCLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [2:0]           state;
    logic [RUN_CNT_W-1:0] runs_target;
    logic [CYCLE_W-1:0]   cnt;
    logic [GAP_W-1:0]     gap_cnt;
    logic [CYCLE_W-1:0]   lat;
    logic [TOTAL_W:0]     total_sum;
    logic [TOTAL_W-1:0]   total_nxt;
    logic [RUN_CNT_W-1:0] runs_inc;

    // Latency of a run finishing this cycle: done right after START counts as 1.
    always_comb begin
        lat       = (cnt == CYC_MAX) ? CYC_MAX : cnt + CYCLE_W'(1);
        total_sum = {1'b0, total_cycles} + (TOTAL_W + 1)'(lat);
        total_nxt = total_sum[TOTAL_W] ? {TOTAL_W{1'b1}} : total_sum[TOTAL_W-1:0];
        runs_inc  = runs_done + RUN_CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            runs_target  <= '0;
            runs_done    <= '0;
            cnt          <= '0;
            gap_cnt      <= '0;
            last_cycles  <= '0;
            min_cycles   <= CYC_MAX;
            max_cycles   <= '0;
            total_cycles <= '0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go) begin
                        runs_target  <= num_runs;
                        runs_done    <= '0;
                        last_cycles  <= '0;
                        min_cycles   <= CYC_MAX;
                        max_cycles   <= '0;
                        total_cycles <= '0;
                        timeout      <= 1'b0;
                        state        <= (num_runs == '0) ? S_FINISH : S_START;
                    end
                end
                S_START: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done landing on the last watchdog cycle still counts as completion.
                    if (done_port) begin
                        last_cycles  <= lat;
                        total_cycles <= total_nxt;
                        runs_done    <= runs_inc;
                        gap_cnt      <= '0;
                        if (lat < min_cycles) min_cycles <= lat;
                        if (lat > max_cycles) max_cycles <= lat;
                        state <= (runs_inc == runs_target) ? S_FINISH : S_GAP;
                    end else if (cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        state   <= S_FINISH;
                    end else if (cnt != CYC_MAX) begin
                        cnt <= cnt + CYCLE_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) state <= S_START;
                    else gap_cnt <= gap_cnt + GAP_W'(1);
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign start_port    = (state == S_START);
    assign busy          = (state == S_START) || (state == S_WAIT) || (state == S_GAP);
    assign campaign_done = (state == S_FINISH);

`ifdef HLS_RUN_MON_MISMATCH_EN
    logic [CYCLE_W-1:0]   ref_cycles;
    logic                 mm_flag;
    logic [RUN_CNT_W-1:0] mm_cnt;

    // First completed run of a campaign becomes the reference latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            ref_cycles <= '0;
            mm_flag    <= 1'b0;
            mm_cnt     <= '0;
        end else if (state == S_IDLE && go) begin
            mm_flag <= 1'b0;
            mm_cnt  <= '0;
        end else if (state == S_WAIT && done_port) begin
            if (runs_done == '0) begin
                ref_cycles <= lat;
            end else if (lat != ref_cycles) begin
                mm_flag <= 1'b1;
                if (mm_cnt != {RUN_CNT_W{1'b1}}) mm_cnt <= mm_cnt + RUN_CNT_W'(1);
            end
        end
    end

    assign latency_mismatch = mm_flag;
    assign mismatch_count   = mm_cnt;
`else
    assign latency_mismatch = 1'b0;
    assign mismatch_count   = '0;
`endif

endmodule
